mock_uart_fifo: RTL

Parametrised simulation-only UART model for the Aquila device port. It replaces the single-byte TX latch with real TX and RX FIFOs of configurable depth, drains TX to stdout at a programmable rate, and accepts RX bytes from a testbench-side stream port. It adds per-direction interrupt enables and sticky overrun/drop flags, and sits on the core's M_DEVICE bus at BASE_ADDR.

---
 rtl/mock_uart_fifo.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/mock_uart_fifo.sv
// mock_uart_fifo: simulation UART model for the Aquila device port.
// Register window at BASE_ADDR with TX/RX FIFOs, paced TX drain to stdout,
// stream-side RX ingress, per-direction interrupt enables and sticky flags.
// Optional tohost capture register: define MOCK_UART_TOHOST_EN.
module mock_uart_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR = DATA_WIDTH'(32'hC000_0000),
    parameter int unsigned TX_DEPTH = 16,
    parameter int unsigned RX_DEPTH = 16,
    parameter int unsigned TX_DRAIN_CYCLES = 4,
    parameter int unsigned BUS_LATENCY = 10,
    parameter logic [DATA_WIDTH-1:0] TOHOST_ADDR = DATA_WIDTH'(32'hC100_0000)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    dev_strobe,
    input  logic [DATA_WIDTH-1:0]   dev_addr,
    input  logic                    dev_rw,
    input  logic [DATA_WIDTH/8-1:0] dev_byte_enable,
    input  logic [DATA_WIDTH-1:0]   dev_core2dev_data,
    output logic                    dev_data_ready,
    output logic [DATA_WIDTH-1:0]   dev_dev2core_data,
    input  logic                    rx_valid_i,
    input  logic [7:0]              rx_data_i,
    output logic                    rx_ready_o,
    output logic                    tx_valid_o,
    output logic [7:0]              tx_data_o,
`ifdef MOCK_UART_TOHOST_EN
    output logic [31:0]             tohost_o,
`endif
    output logic                    intr_o
);

    localparam int unsigned TX_PW   = $clog2(TX_DEPTH);
    localparam int unsigned TX_CW   = TX_PW + 1;
    localparam int unsigned RX_PW   = $clog2(RX_DEPTH);
    localparam int unsigned RX_CW   = RX_PW + 1;
    localparam int unsigned LAT_W   = $clog2(BUS_LATENCY + 1);
    localparam int unsigned DRAIN_W = $clog2(TX_DRAIN_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACCESS = 2'd1, S_DONE = 2'd2} state_t;

    state_t                r_state, w_state_nxt;
    logic                  w_commit;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [DATA_WIDTH-1:0] r_addr, r_wdata, r_rdata, w_rdata;
    logic                  r_rw, r_data_ready;

    logic [7:0]            r_tx_mem [TX_DEPTH];
    logic [TX_PW-1:0]      r_tx_wr, r_tx_rd;
    logic [TX_CW-1:0]      r_tx_cnt;
    logic [DRAIN_W-1:0]    r_drain_cnt;
    logic                  r_tx_valid;
    logic [7:0]            r_tx_data;

    logic [7:0]            r_rx_mem [RX_DEPTH];
    logic [RX_PW-1:0]      r_rx_wr, r_rx_rd;
    logic [RX_CW-1:0]      r_rx_cnt, w_rx_cnt_nxt;
    logic                  r_rx_ready;

    logic                  r_tx_drop, r_rx_ovr, r_rx_ie, r_tx_ie, r_intr;
    logic                  w_hit, w_rd_rx, w_wr_tx, w_wr_ctl;
    logic                  w_tx_flush, w_rx_flush, w_drop_clr;
    logic                  w_tx_empty, w_tx_full, w_tx_push, w_tx_pop, w_tx_drop_set;
    logic                  w_rx_empty, w_rx_full, w_rx_push, w_rx_pop, w_rx_ovr_set;
    logic [7:0]            w_status;
    logic                  w_unused;

    // Bus FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Bus FSM next state; commit marks the ACCESS->DONE edge
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        case (r_state)
            S_IDLE:   if (dev_strobe) w_state_nxt = S_ACCESS;
            S_ACCESS: if (r_lat_cnt == LAT_W'(BUS_LATENCY - 1)) begin
                          w_state_nxt = S_DONE;
                          w_commit    = 1'b1;
                      end
            S_DONE:   w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Transaction capture, access timer, completion pulse and read data
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lat_cnt    <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rw         <= 1'b0;
            r_data_ready <= 1'b0;
            r_rdata      <= '0;
        end else begin
            r_data_ready <= w_commit;
            if (r_state == S_IDLE && dev_strobe) begin
                r_addr    <= dev_addr;
                r_wdata   <= dev_core2dev_data;
                r_rw      <= dev_rw;
                r_lat_cnt <= '0;
            end else if (r_state == S_ACCESS) begin
                r_lat_cnt <= r_lat_cnt + LAT_W'(1);
            end
            if (w_commit && !r_rw) r_rdata <= w_rdata;
        end
    end

    // Address decode and FIFO/flag control strobes
    always_comb begin
        w_hit         = (r_addr[DATA_WIDTH-1:4] == BASE_ADDR[DATA_WIDTH-1:4]);
        w_rd_rx       = w_commit && !r_rw && w_hit && (r_addr[3:2] == 2'd0);
        w_wr_tx       = w_commit &&  r_rw && w_hit && (r_addr[3:2] == 2'd1);
        w_wr_ctl      = w_commit &&  r_rw && w_hit && (r_addr[3:2] == 2'd3);
        w_tx_flush    = w_wr_ctl && r_wdata[0];
        w_rx_flush    = w_wr_ctl && r_wdata[1];
        w_drop_clr    = w_wr_ctl && r_wdata[2];

        w_tx_empty    = (r_tx_cnt == '0);
        w_tx_full     = (r_tx_cnt == TX_CW'(TX_DEPTH));
        // The cycle after an emission does not count toward the next drain
        w_tx_pop      = !w_tx_empty && !r_tx_valid && !w_tx_flush &&
                        (r_drain_cnt == DRAIN_W'(TX_DRAIN_CYCLES - 1));
        w_tx_push     = w_wr_tx && !w_tx_flush && (!w_tx_full || w_tx_pop);
        w_tx_drop_set = w_wr_tx && w_tx_full && !w_tx_pop;

        w_rx_empty    = (r_rx_cnt == '0);
        w_rx_full     = (r_rx_cnt == RX_CW'(RX_DEPTH));
        w_rx_push     = rx_valid_i && r_rx_ready && !w_rx_flush;
        w_rx_pop      = w_rd_rx && !w_rx_empty && !w_rx_flush;
        w_rx_ovr_set  = rx_valid_i && w_rx_full && !w_rx_flush;
        w_rx_cnt_nxt  = w_rx_flush ? '0 :
                        r_rx_cnt + RX_CW'(w_rx_push) - RX_CW'(w_rx_pop);

        w_status      = {r_tx_drop, r_rx_ovr, r_tx_ie, r_rx_ie,
                         w_tx_full, w_tx_empty, w_rx_full, !w_rx_empty};
    end

    // Read data mux
    always_comb begin
        w_rdata = DATA_WIDTH'(32'hDEADBEEF);
        if (w_hit) begin
            case (r_addr[3:2])
                2'd0:    w_rdata = w_rx_empty ? '0 : DATA_WIDTH'(r_rx_mem[r_rx_rd]);
                2'd2:    w_rdata = DATA_WIDTH'(w_status);
                2'd3:    w_rdata = DATA_WIDTH'({r_tx_ie, r_rx_ie, 4'b0000});
                default: w_rdata = '0;
            endcase
        end
    end

    // FIFO storage writes
    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wr] <= r_wdata[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wr] <= rx_data_i;
    end

    // TX FIFO pointers, drain timer and emission
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_wr     <= '0;
            r_tx_rd     <= '0;
            r_tx_cnt    <= '0;
            r_drain_cnt <= '0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= '0;
        end else begin
            if (w_tx_flush) begin
                r_tx_wr  <= '0;
                r_tx_rd  <= '0;
                r_tx_cnt <= '0;
            end else begin
                if (w_tx_push) r_tx_wr <= r_tx_wr + TX_PW'(1);
                if (w_tx_pop)  r_tx_rd <= r_tx_rd + TX_PW'(1);
                r_tx_cnt <= r_tx_cnt + TX_CW'(w_tx_push) - TX_CW'(w_tx_pop);
            end
            if (w_tx_flush || w_tx_pop || w_tx_empty) r_drain_cnt <= '0;
            else if (!r_tx_valid)                     r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
            r_tx_valid <= w_tx_pop;
            if (w_tx_pop) begin
                r_tx_data <= r_tx_mem[r_tx_rd];
                $write("%c", r_tx_mem[r_tx_rd]);
            end
        end
    end

    // RX FIFO pointers and ready
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rx_wr    <= '0;
            r_rx_rd    <= '0;
            r_rx_cnt   <= '0;
            r_rx_ready <= 1'b0;
        end else begin
            if (w_rx_flush) begin
                r_rx_wr <= '0;
                r_rx_rd <= '0;
            end else begin
                if (w_rx_push) r_rx_wr <= r_rx_wr + RX_PW'(1);
                if (w_rx_pop)  r_rx_rd <= r_rx_rd + RX_PW'(1);
            end
            r_rx_cnt   <= w_rx_cnt_nxt;
            r_rx_ready <= (w_rx_cnt_nxt != RX_CW'(RX_DEPTH));
        end
    end

    // Sticky flags, interrupt enables and registered interrupt
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tx_drop <= 1'b0;
            r_rx_ovr  <= 1'b0;
            r_rx_ie   <= 1'b0;
            r_tx_ie   <= 1'b0;
            r_intr    <= 1'b0;
        end else begin
            if (w_drop_clr)         r_tx_drop <= 1'b0;
            else if (w_tx_drop_set) r_tx_drop <= 1'b1;
            if (w_rx_flush)         r_rx_ovr  <= 1'b0;
            else if (w_rx_ovr_set)  r_rx_ovr  <= 1'b1;
            if (w_wr_ctl) begin
                r_rx_ie <= r_wdata[4];
                r_tx_ie <= r_wdata[5];
            end
            r_intr <= (r_rx_ie && (!w_rx_empty || r_rx_ovr)) || (r_tx_ie && w_tx_empty);
        end
    end

`ifdef MOCK_UART_TOHOST_EN
    logic [31:0] r_tohost;

    // tohost capture
    always_ff @(posedge clk) begin
        if (!rst_n)                                         r_tohost <= '0;
        else if (w_commit && r_rw && r_addr == TOHOST_ADDR) r_tohost <= 32'(r_wdata);
    end

    assign tohost_o = r_tohost;
    assign w_unused = ^{dev_byte_enable, r_addr[1:0], r_wdata};
`else
    assign w_unused = ^{dev_byte_enable, r_addr[1:0], r_wdata, TOHOST_ADDR};
`endif

    assign dev_data_ready    = r_data_ready;
    assign dev_dev2core_data = r_rdata;
    assign rx_ready_o        = r_rx_ready;
    assign tx_valid_o        = r_tx_valid;
    assign tx_data_o         = r_tx_data;
    assign intr_o            = r_intr;

endmodule
